// File: rtl/gs_pkg.sv
// gs_pkg: shared state encoding, default box sizes and 7-segment patterns for the game supervisor
package gs_pkg;
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_HIT  = 3'd2,
    ST_WIN  = 3'd3,
    ST_OVER = 3'd4
  } state_t;
  localparam int DEF_PLAYER_W = 32;
  localparam int DEF_PLAYER_H = 32;
  localparam int DEF_CAR_W = 32;
  localparam int DEF_CAR_H = 32;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  // Active-low {G,F,E,D,C,B,A} pattern for one decimal digit; anything above 9 is blank
  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return SEG_BLANK;
    endcase
  endfunction
endpackage

// File: rtl/aabb_overlap.sv
// aabb_overlap: strict axis-aligned box overlap between the raccoon and one car
module aabb_overlap
  import gs_pkg::*;
#(
  parameter int PLAYER_W = DEF_PLAYER_W,
  parameter int PLAYER_H = DEF_PLAYER_H,
  parameter int CAR_W = DEF_CAR_W,
  parameter int CAR_H = DEF_CAR_H
) (
  input  logic [9:0] i_Raccoon_X,
  input  logic [9:0] i_Raccoon_Y,
  input  logic [9:0] i_Car_X,
  input  logic [9:0] i_Car_Y,
  output logic       o_Overlap
);
  logic [10:0] rx, ry, cx, cy;
  assign rx = {1'b0, i_Raccoon_X};
  assign ry = {1'b0, i_Raccoon_Y};
  assign cx = {1'b0, i_Car_X};
  assign cy = {1'b0, i_Car_Y};
  // Touching edges do not count as a hit, hence strict compares on 11-bit sums
  assign o_Overlap = rx < cx + 11'(CAR_W) && rx + 11'(PLAYER_W) > cx &&
                     ry < cy + 11'(CAR_H) && ry + 11'(PLAYER_H) > cy;
endmodule

// File: rtl/game_supervisor.sv
// game_supervisor: collision check, game FSM, lives/level bookkeeping and board output decode
module game_supervisor
  import gs_pkg::*;
#(
  parameter int N_CARS = 3,
  parameter int MAX_LIVES = 3,
  parameter int MAX_LEVEL = 9,
  parameter int HIT_CYCLES = 25000000,
  parameter int PLAYER_W = DEF_PLAYER_W,
  parameter int PLAYER_H = DEF_PLAYER_H,
  parameter int CAR_W = DEF_CAR_W,
  parameter int CAR_H = DEF_CAR_H,
  localparam int LIVES_W = $clog2(MAX_LIVES + 1)
) (
  input  logic                 i_Clk,
  input  logic                 i_Reset_n,
  input  logic                 i_Clear,
  input  logic                 i_Start,
  input  logic                 i_Level_Up,
  input  logic [9:0]           i_Raccoon_X,
  input  logic [9:0]           i_Raccoon_Y,
  input  logic [10*N_CARS-1:0] i_Car_X,
  input  logic [10*N_CARS-1:0] i_Car_Y,
  output logic [2:0]           o_State,
  output logic [LIVES_W-1:0]   o_Lives,
  output logic [3:0]           o_Level,
  output logic [MAX_LIVES-1:0] o_Lives_LED,
  output logic [6:0]           o_Segment,
  output logic                 o_Respawn,
  output logic                 o_Car_Reset,
  output logic                 o_Freeze
);
  localparam int CNT_W = $clog2(HIT_CYCLES + 1);
  state_t state, state_nx;
  logic [LIVES_W-1:0] lives, lives_nx;
  logic [3:0] level, level_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [N_CARS-1:0] ov;
  logic hit_q, respawn_nx, car_reset_nx;
  for (genvar c = 0; c < N_CARS; c++) begin : g_car
    aabb_overlap #(
      .PLAYER_W(PLAYER_W), .PLAYER_H(PLAYER_H), .CAR_W(CAR_W), .CAR_H(CAR_H)
    ) u_aabb (
      .i_Raccoon_X(i_Raccoon_X),
      .i_Raccoon_Y(i_Raccoon_Y),
      .i_Car_X(i_Car_X[10*c+:10]),
      .i_Car_Y(i_Car_Y[10*c+:10]),
      .o_Overlap(ov[c])
    );
  end
  // State, counters, registered collision flag and one-cycle pulses
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state <= ST_IDLE;
      lives <= '0;
      level <= '0;
      cnt <= '0;
      hit_q <= 1'b0;
      o_Respawn <= 1'b0;
      o_Car_Reset <= 1'b0;
    end else begin
      state <= state_nx;
      lives <= lives_nx;
      level <= level_nx;
      cnt <= cnt_nx;
      hit_q <= !i_Clear && |ov;
      o_Respawn <= respawn_nx;
      o_Car_Reset <= car_reset_nx;
    end
  end
  // Next-state logic; a hit in RUN outranks a simultaneous level-up
  always_comb begin
    state_nx = state;
    lives_nx = lives;
    level_nx = level;
    cnt_nx = cnt;
    respawn_nx = 1'b0;
    car_reset_nx = 1'b0;
    if (i_Clear) begin
      state_nx = ST_IDLE;
      lives_nx = '0;
      level_nx = '0;
      cnt_nx = '0;
    end else begin
      case (state)
        ST_IDLE, ST_WIN, ST_OVER: if (i_Start) begin
          state_nx = ST_RUN;
          lives_nx = LIVES_W'(MAX_LIVES);
          level_nx = '0;
          respawn_nx = 1'b1;
          car_reset_nx = 1'b1;
        end
        ST_RUN: if (hit_q) begin
          lives_nx = lives == '0 ? lives : lives - 1'b1;
          state_nx = lives <= LIVES_W'(1) ? ST_OVER : ST_HIT;
          respawn_nx = 1'b1;
          cnt_nx = CNT_W'(HIT_CYCLES - 1);
        end else if (i_Level_Up && level < 4'(MAX_LEVEL)) begin
          level_nx = level + 4'd1;
          respawn_nx = 1'b1;
          state_nx = level_nx == 4'(MAX_LEVEL) ? ST_WIN : ST_RUN;
          car_reset_nx = level_nx == 4'(MAX_LEVEL);
        end
        ST_HIT: begin
          state_nx = cnt == '0 ? ST_RUN : ST_HIT;
          cnt_nx = cnt == '0 ? cnt : cnt - 1'b1;
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end
  for (genvar i = 0; i < MAX_LIVES; i++) begin : g_led
    assign o_Lives_LED[i] = lives > LIVES_W'(i);
  end
  assign o_State = state;
  assign o_Lives = lives;
  assign o_Level = level;
  assign o_Freeze = state == ST_HIT;
  assign o_Segment = seg7(level);
endmodule
